// File: rtl/prio_irq_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package prio_irq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_PRESENT = 3'b010,
        ST_GAP     = 3'b100
    } state_t;

    function automatic int lvl_w(input int num_lvl);
        return (num_lvl > 1) ? $clog2(num_lvl) : 1;
    endfunction

    function automatic int id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int flat_idx(input int lvl, input int ch, input int num_ch);
        return lvl * num_ch + ch;
    endfunction

endpackage

// File: rtl/prio_irq_ff1.sv
// Combinational find-first-set: lowest set bit of vec wins.
module prio_irq_ff1 #(
    parameter int N = 9,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic         hit,
    output logic [W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !hit) begin
                hit = 1'b1;
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_irq_ctrl.sv
// Edge-latched, enable-gated priority interrupt controller with valid/ack
// presentation and per-level activity flags.
module prio_irq_ctrl
    import prio_irq_pkg::*;
#(
    parameter int NUM_CH  = 9,
    parameter int NUM_LVL = 3,
    parameter int LW      = lvl_w(NUM_LVL),
    parameter int IDW     = id_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_LVL*NUM_CH-1:0] req_i,
    input  logic                     en_wr,
    input  logic [NUM_LVL*NUM_CH-1:0] en_wdata,
    output logic                     irq_valid,
    output logic [LW-1:0]            irq_lvl,
    output logic [IDW-1:0]           irq_id,
    input  logic                     irq_ack,
    output logic [NUM_LVL-1:0]       lvl_active
);

    localparam int NB = NUM_LVL * NUM_CH;

    state_t          state_q, state_n;
    logic [NB-1:0]   pending, enable, req_q;
    logic [NB-1:0]   eff, edges, clr;
    logic            load, ack_take;

    logic [NUM_LVL-1:0] lvl_hit;
    logic [IDW-1:0]     lvl_idx [NUM_LVL];
    logic               win_hit;
    logic [LW-1:0]      win_lvl;
    logic [IDW-1:0]     win_id;

    assign eff   = pending & enable;
    assign edges = req_i & ~req_q;

    for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl
        prio_irq_ff1 #(.N(NUM_CH), .W(IDW)) u_ff1 (
            .vec (eff[l*NUM_CH +: NUM_CH]),
            .hit (lvl_hit[l]),
            .idx (lvl_idx[l])
        );
    end

    always_comb begin
        win_hit = 1'b0;
        win_lvl = '0;
        win_id  = '0;
        for (int unsigned l = 0; l < NUM_LVL; l++) begin
            if (lvl_hit[l] && !win_hit) begin
                win_hit = 1'b1;
                win_lvl = LW'(l);
                win_id  = lvl_idx[l];
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        load     = 1'b0;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_hit) begin
                    load    = 1'b1;
                    state_n = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    ack_take = 1'b1;
                    state_n  = ST_GAP;
                end
            end
            ST_GAP:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Clear mask for the presented bit; the edge OR below lets a same-cycle set win.
    assign clr = ack_take ? (NB'(1) << flat_idx(int'(irq_lvl), int'(irq_id), NUM_CH)) : '0;

    assign irq_valid = (state_q == ST_PRESENT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending    <= '0;
            enable     <= '0;
            req_q      <= '1;
            irq_lvl    <= '0;
            irq_id     <= '0;
            lvl_active <= '0;
        end else begin
            state_q    <= state_n;
            pending    <= (pending & ~clr) | edges;
            req_q      <= req_i;
            lvl_active <= lvl_hit;
            if (en_wr) begin
                enable <= en_wdata;
            end
            if (load) begin
                irq_lvl <= win_lvl;
                irq_id  <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Directed bench for prio_irq_ctrl with a cycle-level reference model.
module tb_prio_irq_ctrl;

    localparam int NCH = 9;
    localparam int NLV = 3;
    localparam int NB  = NCH * NLV;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] req_i;
    logic          en_wr;
    logic [NB-1:0] en_wdata;
    logic          irq_valid;
    logic [1:0]    irq_lvl;
    logic [3:0]    irq_id;
    logic          irq_ack;
    logic [2:0]    lvl_active;

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    prio_irq_ctrl #(.NUM_CH(NCH), .NUM_LVL(NLV)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .en_wr      (en_wr),
        .en_wdata   (en_wdata),
        .irq_valid  (irq_valid),
        .irq_lvl    (irq_lvl),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .lvl_active (lvl_active)
    );

    always #5 clk = ~clk;

    // Reference model: pending set, enable set, and the current presentation.
    logic [NB-1:0] m_pend, m_en, m_prev;
    bit            m_valid, m_gap;
    logic [1:0]    m_lvl;
    logic [3:0]    m_id;
    logic [2:0]    m_act;

    always @(posedge clk) begin : model
        logic [NB-1:0] eff, clrm;
        bit found;
        int wl, wc;
        if (rst) begin
            m_pend = '0; m_en = '0; m_prev = '1;
            m_valid = 0; m_gap = 0; m_lvl = '0; m_id = '0; m_act = '0;
        end else begin
            eff = m_pend & m_en;
            found = 0; wl = 0; wc = 0;
            for (int l = 0; l < NLV; l++)
                for (int c = 0; c < NCH; c++)
                    if (!found && eff[l*NCH + c]) begin
                        found = 1; wl = l; wc = c;
                    end
            for (int l = 0; l < NLV; l++) m_act[l] = |eff[l*NCH +: NCH];
            clrm = '0;
            if (m_valid && irq_ack) begin
                clrm[int'(m_lvl)*NCH + int'(m_id)] = 1'b1;
                m_valid = 0;
                m_gap = 1;
            end else if (m_gap) begin
                m_gap = 0;
            end else if (!m_valid && found) begin
                m_valid = 1;
                m_lvl = 2'(wl);
                m_id  = 4'(wc);
            end
            m_pend = (m_pend & ~clrm) | (req_i & ~m_prev);
            m_prev = req_i;
            if (en_wr) m_en = en_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_valid", 32'(irq_valid), 32'(m_valid));
            check("cyc_lvl", 32'(irq_lvl), 32'(m_lvl));
            check("cyc_id", 32'(irq_id), 32'(m_id));
            check("cyc_act", 32'(lvl_active), 32'(m_act));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int b);
        req_i[b] = 1'b1;
        tick();
        req_i[b] = 1'b0;
    endtask

    task automatic do_ack;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic present(input string name, input int lv, input int id);
        check({name, "_v"}, 32'(irq_valid), 32'd1);
        check({name, "_l"}, 32'(irq_lvl), 32'(lv));
        check({name, "_i"}, 32'(irq_id), 32'(id));
    endtask

    initial begin
        rst = 1'b1; req_i = '0; en_wr = 1'b0; en_wdata = '0; irq_ack = 1'b0;
        tick(); tick();
        chk_on = 1'b1;
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_lvl", 32'(irq_lvl), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_act", 32'(lvl_active), 32'd0);
        rst = 1'b0;

        // Single request on level 2 channel 4.
        en_wr = 1'b1; en_wdata = '1; tick(); en_wr = 1'b0;
        pulse(22);
        check("t1_early", 32'(irq_valid), 32'd0);
        tick();
        present("t1", 2, 4);
        check("t1_act", 32'(lvl_active), 32'b100);
        check("t1_model_lvl", 32'(m_lvl), 32'd2);
        do_ack();
        check("t1_ackdrop", 32'(irq_valid), 32'd0);
        tick(); tick();
        check("t1_quiet", 32'(irq_valid), 32'd0);

        // Two levels at once; ack held through GAP is ignored there.
        req_i[5] = 1'b1; req_i[12] = 1'b1; tick(); req_i = '0;
        tick();
        present("t2a", 0, 5);
        check("t2_model_id", 32'(m_id), 32'd5);
        irq_ack = 1'b1; tick(); tick(); irq_ack = 1'b0;
        check("t2_gap", 32'(irq_valid), 32'd0);
        tick();
        present("t2b", 1, 3);
        do_ack(); tick(); tick();

        // Disabled request latches but is not presented until enabled.
        en_wr = 1'b1; en_wdata = '0; tick(); en_wr = 1'b0;
        pulse(0); tick(); tick();
        check("t3_masked", 32'(irq_valid), 32'd0);
        check("t3_act", 32'(lvl_active), 32'd0);
        en_wr = 1'b1; en_wdata = NB'(1); tick(); en_wr = 1'b0;
        check("t3_oldenable", 32'(irq_valid), 32'd0);
        tick();
        present("t3", 0, 0);
        do_ack(); tick(); tick();
        en_wr = 1'b1; en_wdata = '1; tick(); en_wr = 1'b0;

        // Presentation stays frozen while a higher-priority request arrives.
        pulse(26); tick();
        present("t4a", 2, 8);
        pulse(1);
        present("t4hold1", 2, 8);
        tick();
        present("t4hold2", 2, 8);
        check("t4_act", 32'(lvl_active), 32'b101);
        do_ack(); tick(); tick();
        present("t4b", 0, 1);
        do_ack(); tick(); tick();

        // Re-rise in the ack cycle keeps the bit pending.
        pulse(3); tick();
        present("t5a", 0, 3);
        irq_ack = 1'b1; req_i[3] = 1'b1; tick();
        irq_ack = 1'b0; req_i[3] = 1'b0;
        check("t5_ackdrop", 32'(irq_valid), 32'd0);
        tick(); tick();
        present("t5b", 0, 3);
        do_ack(); tick(); tick();

        // Reset during PRESENT with the line held high.
        req_i[7] = 1'b1; tick(); tick();
        present("t6a", 0, 7);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_valid", 32'(irq_valid), 32'd0);
        check("t6_lvl", 32'(irq_lvl), 32'd0);
        check("t6_id", 32'(irq_id), 32'd0);
        check("t6_act", 32'(lvl_active), 32'd0);
        en_wr = 1'b1; en_wdata = '1; tick(); en_wr = 1'b0;
        tick(); tick(); tick();
        check("t6_noedge", 32'(irq_valid), 32'd0);
        req_i[7] = 1'b0; tick();
        pulse(7); tick();
        present("t6b", 0, 7);
        do_ack(); tick(); tick();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
